siphash_msg_padder: RTL and testbench
=====================================

// Module: siphash_msg_padder
// PURPOSE
// Upstream feeder for siphash_core. Accepts a byte stream with valid/ready/last handshake,
// packs bytes little-endian into 64-bit message words and applies SipHash padding: the final
// word carries the message length mod 256 in bits [63:56]. Sequences the core's
// initalize/compress/finalize pulses against its ready output. The key and round counts are
// wired to the core directly, outside this block.
// PARAMETERS
// none (SipHash word size of 64 bits and length field of 8 bits are fixed by the algorithm)
// PORTS
// clk            in   1   system clock, rising edge
// reset          in   1   asynchronous, active-high reset
// start          in   1   begin new message; sampled only in IDLE
// start_empty    in   1   with start: message is zero-length, no bytes follow
// data_in        in   8   message byte
// data_valid     in   1   data_in valid
// data_last      in   1   with data_valid: this byte is the final byte
// data_ready     out  1   block accepts a byte this cycle (valid & ready = transfer)
// core_ready     in   1   siphash_core ready
// core_initalize out  1   one-cycle pulse to core
// core_compress  out  1   one-cycle pulse to core
// core_finalize  out  1   one-cycle pulse to core
// core_mi        out  64  message word to core; stable from compress pulse until core_ready returns
// busy           out  1   message in progress (start accepted, done not yet given)
// done           out  1   one-cycle pulse: finalization complete, core digest valid
// BEHAVIOUR
// Reset: all outputs 0, core_mi = 0, byte_ctr = 0, len_ctr = 0, pad_pend = 0, state IDLE.
//   Reset aborts any message mid-operation. The core must be reset together with this block.
// All outputs are registered. The FSM moves through these states:
//   IDLE  -> INIT on start.
//   INIT: pulse core_initalize for 1 cycle (core ready is high), then next state:
//     COLLECT, or PAD if start_empty.
//   COLLECT: data_ready = 1. On each transfer:
//     - write data_in into byte lane byte_ctr (bits 8*byte_ctr+7 : 8*byte_ctr);
//     - byte_ctr += 1; len_ctr += 1 (8-bit, wraps 255 -> 0).
//   Transfer with byte_ctr == 7 (8th byte of the word):
//     core_mi <= full word; set pad_pend = data_last; -> CISSUE.
//   Transfer with data_last and byte_ctr < 7:
//     core_mi <= bytes, zero fill, [63:56] = len_ctr + 1; -> CISSUE, next after = FISSUE.
//   PAD: core_mi <= {len_ctr, 56'h0}; clear pad_pend; -> CISSUE, next after = FISSUE.
//   CISSUE: wait core_ready = 1, then pulse core_compress 1 cycle; -> CWAIT.
//   CWAIT: wait core_ready = 1 (core drops ready the cycle after the pulse), then:
//     -> FISSUE if the word was the padded word; else PAD if pad_pend; else COLLECT.
//     byte_ctr = 0 and the word buffer is cleared on leaving CWAIT.
//   FISSUE: pulse core_finalize 1 cycle; -> FWAIT.
//   FWAIT: wait core_ready = 1, then pulse done and clear busy; -> IDLE.
// data_ready = 0 in every state except COLLECT (backpressure during compression).
// Exactly one padded word per message. A message of 8n bytes gets an extra length-only word.
// Simultaneous events:
//   start while busy is ignored; data_valid outside COLLECT is ignored.
//   data_last without data_valid has no effect.
// Never assert more than one core pulse in the same cycle.
// Per-word latency = 1 (issue) + core compression time; core_mi is held across it.
// TESTING
// T1 empty: start + start_empty -> one compress, mi = 64'h0; key 00..0f, 2-4 rounds
//    -> core digest 64'h726fdb47dd0e0e31; done pulses once.
// T2 15 bytes 00..0e -> mi 64'h0706050403020100 then 64'h0f0e0d0c0b0a0908;
//    finalize; digest 64'ha129ca6149be45e5.
// T3 8 bytes 00..07 -> mi 64'h0706050403020100 then 64'h0800000000000000; two compresses.
// T4 256 bytes of 0xff -> 32 full words, then final mi = 64'h0000000000000000 (length wraps to 0).
// T5 hold core_ready low 10 cycles after a compress -> data_ready stays 0, core_mi stable,
//    no second pulse.
// T6 reset asserted mid-CWAIT -> all outputs 0 next cycle; new start runs T2 correctly.

Source files
------------

// File: rtl/siphash_msg_padder.sv
// Byte-stream front end for siphash_core: packs bytes little-endian into 64-bit words,
// appends the SipHash length byte and sequences initialize/compress/finalize against core_ready.
module siphash_msg_padder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        start_empty,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        data_last,
    output logic        data_ready,
    input  logic        core_ready,
    output logic        core_initalize,
    output logic        core_compress,
    output logic        core_finalize,
    output logic [63:0] core_mi,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        COLLECT,
        PAD,
        CISSUE,
        CWAIT,
        FISSUE,
        FWAIT
    } state_t;

    state_t      state_q;
    logic [2:0]  byte_ctr_q;
    logic [7:0]  len_ctr_q;
    logic        pad_pend_q;
    logic        padded_q;
    logic        empty_q;
    logic [55:0] buf_q;

    logic        data_ready_q;
    logic        core_initalize_q;
    logic        core_compress_q;
    logic        core_finalize_q;
    logic [63:0] core_mi_q;
    logic        busy_q;
    logic        done_q;

    logic [63:0] word_d;
    logic [7:0]  len_inc_d;
    logic        xfer_d;

    // Buffered bytes with the incoming byte merged into its lane.
    always_comb begin
        word_d = {8'h00, buf_q};
        word_d[{byte_ctr_q, 3'b000} +: 8] = data_in;
        len_inc_d = len_ctr_q + 8'd1;
        xfer_d    = data_valid && data_ready_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            byte_ctr_q       <= 3'd0;
            len_ctr_q        <= 8'd0;
            pad_pend_q       <= 1'b0;
            padded_q         <= 1'b0;
            empty_q          <= 1'b0;
            buf_q            <= 56'h0;
            data_ready_q     <= 1'b0;
            core_initalize_q <= 1'b0;
            core_compress_q  <= 1'b0;
            core_finalize_q  <= 1'b0;
            core_mi_q        <= 64'h0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            core_initalize_q <= 1'b0;
            core_compress_q  <= 1'b0;
            core_finalize_q  <= 1'b0;
            done_q           <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q          <= INIT;
                        core_initalize_q <= 1'b1;
                        busy_q           <= 1'b1;
                        empty_q          <= start_empty;
                        byte_ctr_q       <= 3'd0;
                        len_ctr_q        <= 8'd0;
                        pad_pend_q       <= 1'b0;
                        padded_q         <= 1'b0;
                        buf_q            <= 56'h0;
                    end
                end

                INIT: begin
                    if (empty_q) begin
                        state_q <= PAD;
                    end else begin
                        state_q      <= COLLECT;
                        data_ready_q <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (xfer_d) begin
                        byte_ctr_q <= byte_ctr_q + 3'd1;
                        len_ctr_q  <= len_inc_d;
                        if (byte_ctr_q == 3'd7) begin
                            core_mi_q    <= word_d;
                            pad_pend_q   <= data_last;
                            padded_q     <= 1'b0;
                            data_ready_q <= 1'b0;
                            state_q      <= CISSUE;
                        end else if (data_last) begin
                            // Short final word: the length byte rides in the top lane.
                            core_mi_q    <= {len_inc_d, word_d[55:0]};
                            padded_q     <= 1'b1;
                            data_ready_q <= 1'b0;
                            state_q      <= CISSUE;
                        end else begin
                            buf_q <= word_d[55:0];
                        end
                    end
                end

                PAD: begin
                    core_mi_q  <= {len_ctr_q, 56'h0};
                    pad_pend_q <= 1'b0;
                    padded_q   <= 1'b1;
                    state_q    <= CISSUE;
                end

                CISSUE: begin
                    if (core_ready) begin
                        core_compress_q <= 1'b1;
                        state_q         <= CWAIT;
                    end
                end

                CWAIT: begin
                    // The core still shows ready while our pulse is out, so ignore that cycle.
                    if (core_ready && !core_compress_q) begin
                        byte_ctr_q <= 3'd0;
                        buf_q      <= 56'h0;
                        if (padded_q) begin
                            core_finalize_q <= 1'b1;
                            state_q         <= FISSUE;
                        end else if (pad_pend_q) begin
                            state_q <= PAD;
                        end else begin
                            data_ready_q <= 1'b1;
                            state_q      <= COLLECT;
                        end
                    end
                end

                FISSUE: begin
                    state_q <= FWAIT;
                end

                FWAIT: begin
                    if (core_ready) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q      <= IDLE;
                    data_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready     = data_ready_q;
    assign core_initalize = core_initalize_q;
    assign core_compress  = core_compress_q;
    assign core_finalize  = core_finalize_q;
    assign core_mi        = core_mi_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_siphash_msg_padder.sv
// Directed bench for siphash_msg_padder with a behavioural stand-in for siphash_core's
// ready handshake; compressed words are captured and compared against hand-computed values.
module tb_siphash_msg_padder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        startEmpty;
    logic [7:0]  dataIn;
    logic        dataValid;
    logic        dataLast;
    logic        dataReady;
    logic        coreReady;
    logic        coreInit;
    logic        coreComp;
    logic        coreFin;
    logic [63:0] coreMi;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int lat = 4;
    int coreCnt = 0;
    int initCount = 0;
    int compCount = 0;
    int finCount = 0;
    int doneCount = 0;
    int multiPulse = 0;
    logic [63:0] miQ[$];

    always #5 clk = ~clk;

    siphash_msg_padder dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_empty    (startEmpty),
        .data_in        (dataIn),
        .data_valid     (dataValid),
        .data_last      (dataLast),
        .data_ready     (dataReady),
        .core_ready     (coreReady),
        .core_initalize (coreInit),
        .core_compress  (coreComp),
        .core_finalize  (coreFin),
        .core_mi        (coreMi),
        .busy           (busy),
        .done           (done)
    );

    assign coreReady = (coreCnt == 0);

    // Core stand-in: any pulse drops ready for 'lat' cycles; also logs pulses and words.
    always @(negedge clk) begin
        if (reset) begin
            coreCnt <= 0;
        end else begin
            if (coreInit || coreComp || coreFin) coreCnt <= lat;
            else if (coreCnt > 0) coreCnt <= coreCnt - 1;
            if (coreInit) initCount <= initCount + 1;
            if (coreComp) begin
                compCount <= compCount + 1;
                miQ.push_back(coreMi);
            end
            if (coreFin) finCount <= finCount + 1;
            if (done) doneCount <= doneCount + 1;
            if (int'(coreInit) + int'(coreComp) + int'(coreFin) > 1) multiPulse <= multiPulse + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] miAt(input int idx);
        if (idx < miQ.size()) return miQ[idx];
        return 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    task automatic sendByte(input logic [7:0] b, input logic last);
        int t = 0;
        dataIn    = b;
        dataValid = 1'b1;
        dataLast  = last;
        while (dataReady !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) checkOutput("sendByte_timeout", 64'(t), 64'd0);
        @(negedge clk);
        dataValid = 1'b0;
        dataLast  = 1'b0;
    endtask

    task automatic waitDone(input int base);
        int t = 0;
        while (doneCount == base && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] first, input bit incr, input int n);
        int base = doneCount;
        @(negedge clk);
        start      = 1'b1;
        startEmpty = (n == 0);
        @(negedge clk);
        start      = 1'b0;
        startEmpty = 1'b0;
        for (int i = 0; i < n; i++) sendByte(incr ? first + 8'(i) : first, i == n - 1);
        waitDone(base);
    endtask

    task automatic checkT2(input string pfx, input int c0, input int f0, input int d0, input int q0);
        checkOutput({pfx, "_comp"}, 64'(compCount - c0), 64'd2);
        checkOutput({pfx, "_mi0"}, miAt(q0), 64'h0706050403020100);
        checkOutput({pfx, "_mi1"}, miAt(q0 + 1), 64'h0f0e0d0c0b0a0908);
        checkOutput({pfx, "_fin"}, 64'(finCount - f0), 64'd1);
        checkOutput({pfx, "_done"}, 64'(doneCount - d0), 64'd1);
        checkOutput({pfx, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int c0, i0, f0, d0, q0, t, bad;
        logic [63:0] snap;
        logic drSeen, miChg;

        reset = 1'b1; start = 1'b0; startEmpty = 1'b0;
        dataIn = 8'h00; dataValid = 1'b0; dataLast = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", 64'({dataReady, busy, done, coreInit, coreComp, coreFin}), 64'd0);
        checkOutput("reset_mi", coreMi, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // T1: empty message
        c0 = compCount; i0 = initCount; f0 = finCount; d0 = doneCount; q0 = miQ.size();
        applyStimulus(8'h00, 1'b1, 0);
        checkOutput("T1_init", 64'(initCount - i0), 64'd1);
        checkOutput("T1_comp", 64'(compCount - c0), 64'd1);
        checkOutput("T1_mi", miAt(q0), 64'h0);
        checkOutput("T1_fin", 64'(finCount - f0), 64'd1);
        checkOutput("T1_done", 64'(doneCount - d0), 64'd1);

        // T2: 15 bytes 00..0e
        c0 = compCount; f0 = finCount; d0 = doneCount; q0 = miQ.size();
        applyStimulus(8'h00, 1'b1, 15);
        checkT2("T2", c0, f0, d0, q0);

        // T3: 8 bytes needs a separate length-only word
        c0 = compCount; d0 = doneCount; q0 = miQ.size();
        applyStimulus(8'h00, 1'b1, 8);
        checkOutput("T3_comp", 64'(compCount - c0), 64'd2);
        checkOutput("T3_mi0", miAt(q0), 64'h0706050403020100);
        checkOutput("T3_mi1", miAt(q0 + 1), 64'h0800000000000000);
        checkOutput("T3_done", 64'(doneCount - d0), 64'd1);

        // T4: 256 bytes of ff, length byte wraps to zero
        c0 = compCount; d0 = doneCount; q0 = miQ.size();
        applyStimulus(8'hff, 1'b0, 256);
        checkOutput("T4_comp", 64'(compCount - c0), 64'd33);
        bad = 0;
        for (int i = 0; i < 32; i++) if (miAt(q0 + i) !== 64'hffff_ffff_ffff_ffff) bad++;
        checkOutput("T4_fullwords", 64'(bad), 64'd0);
        checkOutput("T4_last", miAt(q0 + 32), 64'h0);
        checkOutput("T4_done", 64'(doneCount - d0), 64'd1);

        // T5: core holds ready low after a compress
        c0 = compCount; d0 = doneCount; q0 = miQ.size();
        lat = 14;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checkOutput("T5_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) sendByte(8'h10 + 8'(i), 1'b0);
        t = 0;
        while (compCount == c0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        snap = coreMi; drSeen = 1'b0; miChg = 1'b0;
        dataIn = 8'h18; dataValid = 1'b1; dataLast = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (dataReady !== 1'b0) drSeen = 1'b1;
            if (coreMi !== snap) miChg = 1'b1;
        end
        checkOutput("T5_ready_held", 64'(drSeen), 64'd0);
        checkOutput("T5_mi_stable", 64'(miChg), 64'd0);
        checkOutput("T5_one_pulse", 64'(compCount - c0), 64'd1);
        checkOutput("T5_mi_held", snap, 64'h1716151413121110);
        sendByte(8'h18, 1'b1);
        waitDone(d0);
        lat = 4;
        checkOutput("T5_comp", 64'(compCount - c0), 64'd2);
        checkOutput("T5_mi1", miAt(q0 + 1), 64'h0900000000000018);
        checkOutput("T5_done", 64'(doneCount - d0), 64'd1);

        // T6: reset in the middle of CWAIT, then a clean T2 rerun
        c0 = compCount;
        lat = 20;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 8; i++) sendByte(8'(i), 1'b0);
        t = 0;
        while (compCount == c0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("T6_ctrl", 64'({dataReady, busy, done, coreInit, coreComp, coreFin}), 64'd0);
        checkOutput("T6_mi", coreMi, 64'h0);
        reset = 1'b0;
        lat = 4;
        @(negedge clk);
        c0 = compCount; f0 = finCount; d0 = doneCount; q0 = miQ.size();
        applyStimulus(8'h00, 1'b1, 15);
        checkT2("T6", c0, f0, d0, q0);

        checkOutput("pulse_overlap", 64'(multiPulse), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
